// File: rtl/countdown_timer_pkg.sv
// Shared state encoding and widths for the countdown timer.
package countdown_timer_pkg;

    localparam int unsigned STATE_W = 2;

    // 2'd3 is not a legal encoding; the FSM recovers from it to ST_IDLE.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/countdown_timer.sv
// Loadable saturating down-counter with valid/ready load and one-cycle done pulse.
// Optional periodic mode: define COUNTDOWN_TIMER_AUTO_RELOAD_EN.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STEP       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_value,
    output logic                  load_ready,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CMP_W = DATA_WIDTH + 1;
    localparam logic [CMP_W-1:0]      STEP_CMP = CMP_W'(STEP);
    localparam logic [DATA_WIDTH-1:0] STEP_DEC = DATA_WIDTH'(STEP);

    state_e                  state;
    state_e                  state_d;
    logic [DATA_WIDTH-1:0]   count_d;
    logic                    load_ready_d;
    logic                    busy_d;
    logic                    done_d;
    logic                    accept;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    logic [DATA_WIDTH-1:0]   reload;
    logic [DATA_WIDTH-1:0]   reload_d;
`endif

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_d      = state;
        count_d      = count;
        accept       = load_valid && load_ready;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        reload_d     = reload;
        if (accept) begin
            reload_d = load_value;
        end
`endif

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    count_d = load_value;
                    state_d = (load_value != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else if (en) begin
                    // Compare one bit wider so a near-full STEP cannot alias.
                    if ({1'b0, count} > STEP_CMP) begin
                        count_d = count - STEP_DEC;
                    end else begin
                        count_d = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                if (abort) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    count_d = reload;
                    state_d = (reload != '0) ? ST_RUN : ST_DONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        load_ready_d = (state_d != ST_DONE);
`else
        load_ready_d = (state_d == ST_IDLE);
`endif
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            reload     <= '0;
`endif
        end else begin
            state      <= state_d;
            count      <= count_d;
            load_ready <= load_ready_d;
            busy       <= busy_d;
            done       <= done_d;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            reload     <= reload_d;
`endif
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: STEP=1 and STEP=3 instances, directed vectors.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en0 = 1'b0, lv0 = 1'b0, ab0 = 1'b0;
    logic [7:0] lval0 = '0;
    logic       en1 = 1'b0, lv1 = 1'b0, ab1 = 1'b0;
    logic [7:0] lval1 = '0;
    logic [7:0] cnt0, cnt1;
    logic       rdy0, busy0, done0;
    logic       rdy1, busy1, done1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] cnt;
        logic       busy;
        logic       done;
        logic       rdy;
        string      name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    countdown_timer #(.DATA_WIDTH(8), .STEP(1)) u_dut0 (
        .clk(clk), .rst(rst), .en(en0), .load_valid(lv0), .load_value(lval0),
        .load_ready(rdy0), .abort(ab0), .count(cnt0), .busy(busy0), .done(done0)
    );

    countdown_timer #(.DATA_WIDTH(8), .STEP(3)) u_dut1 (
        .clk(clk), .rst(rst), .en(en1), .load_valid(lv1), .load_value(lval1),
        .load_ready(rdy1), .abort(ab1), .count(cnt1), .busy(busy1), .done(done1)
    );

    // Drive one cycle of inputs on dut d and queue the state expected after the next edge.
    task automatic step(input int d, input logic r, input logic e, input logic v,
                        input logic [7:0] val, input logic ab,
                        input logic [7:0] xc, input logic xb, input logic xd,
                        input logic xr, input string nm);
        exp_t x;
        @(negedge clk);
        rst = r;
        en0 = 1'b0; lv0 = 1'b0; lval0 = '0; ab0 = 1'b0;
        en1 = 1'b0; lv1 = 1'b0; lval1 = '0; ab1 = 1'b0;
        if (d == 0) begin
            en0 = e; lv0 = v; lval0 = val; ab0 = ab;
        end else begin
            en1 = e; lv1 = v; lval1 = val; ab1 = ab;
        end
        x.cnt = xc; x.busy = xb; x.done = xd; x.rdy = xr; x.name = nm;
        if (d == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    task automatic check(input int d, input exp_t x);
        logic [10:0] act;
        logic [10:0] req;
        if (d == 0) act = {cnt0, busy0, done0, rdy0};
        else        act = {cnt1, busy1, done1, rdy1};
        req = {x.cnt, x.busy, x.done, x.rdy};
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s dut%0d: got count=%0d busy=%b done=%b load_ready=%b, expected count=%0d busy=%b done=%b load_ready=%b",
                     x.name, d, act[10:3], act[2], act[1], act[0],
                     req[10:3], req[2], req[1], req[0]);
        end
    endtask

    // Monitor: compare shortly after each active edge, independent of stimulus.
    always @(posedge clk) begin
        #1;
        if (q0.size() > 0) check(0, q0.pop_front());
        if (q1.size() > 0) check(1, q1.pop_front());
    end

    initial begin
        // Reset, with load and abort offered that must be ignored.
        step(0, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "reset");
        step(0, 1'b0, 1'b1, 1'b1, 8'h44,  1'b1, 8'd0, 1'b0, 1'b0, 1'b1, "reset_ignores_load");

`ifndef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        // Load 5, STEP=1.
        step(0, 1'b1, 1'b1, 1'b1, 8'd5, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0, "t1_load");
        for (int i = 4; i >= 1; i--)
            step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'(i), 1'b1, 1'b0, 1'b0, "t1_dec");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, "t1_done");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "t1_ready");

        // STEP=3: load 7 saturates 1 -> 0; load 3 hits the count==STEP boundary.
        step(1, 1'b1, 1'b1, 1'b1, 8'd7, 1'b0, 8'd7, 1'b1, 1'b0, 1'b0, "t2_load7");
        step(1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0, "t2_dec4");
        step(1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, "t2_dec1");
        step(1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, "t2_sat_done");
        step(1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "t2_idle");
        step(1, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0, "t2_load3");
        step(1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, "t2_eq_step_done");
        step(1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "t2_idle2");

        // Load 4, en low for three cycles after the first decrement.
        step(0, 1'b1, 1'b1, 1'b1, 8'd4, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0, "t3_load");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0, "t3_dec");
        for (int i = 0; i < 3; i++)
            step(0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0, "t3_hold");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0, "t3_dec2");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, "t3_dec1");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, "t3_done");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "t3_idle");

        // Load 9, abort with en high at count 2; abort in IDLE is a no-op.
        step(0, 1'b1, 1'b1, 1'b1, 8'd9, 1'b0, 8'd9, 1'b1, 1'b0, 1'b0, "t4_load");
        for (int i = 8; i >= 2; i--)
            step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'(i), 1'b1, 1'b0, 1'b0, "t4_dec");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, "t4_abort");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, "t4_abort_idle");

        // Reset mid-run with a load offered, then load 0 straight to DONE, abort in DONE.
        step(0, 1'b1, 1'b1, 1'b1, 8'd8,  1'b0, 8'd8, 1'b1, 1'b0, 1'b0, "t5_load");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 8'd7, 1'b1, 1'b0, 1'b0, "t5_dec7");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 8'd6, 1'b1, 1'b0, 1'b0, "t5_dec6");
        step(0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "t5_reset_midrun");
        step(0, 1'b1, 1'b1, 1'b1, 8'd0,  1'b0, 8'd0, 1'b1, 1'b1, 1'b0, "t5_load0_done");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0,  1'b1, 8'd0, 1'b0, 1'b0, 1'b1, "t5_done_abort");

        // Load held valid while busy is not taken until IDLE.
        step(0, 1'b1, 1'b1, 1'b1, 8'd3,  1'b0, 8'd3, 1'b1, 1'b0, 1'b0, "t6_load");
        step(0, 1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0, "t6_run_noload");
        step(0, 1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, "t6_run_noload");
        step(0, 1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, "t6_done");
        step(0, 1'b1, 1'b1, 1'b1, 8'd2,  1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "t6_done_exit");
        step(0, 1'b1, 1'b1, 1'b1, 8'd2,  1'b0, 8'd2, 1'b1, 1'b0, 1'b0, "t6_held_accept");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 8'd1, 1'b1, 1'b0, 1'b0, "t6_dec");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 8'd0, 1'b1, 1'b1, 1'b0, "t6_done2");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "t6_idle");
`else
        // Auto reload: load 3, then a RUN load of 1 takes effect at the next reload.
        step(0, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1, "ar_load3");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b1, "ar_dec2");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1, "ar_dec1");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, "ar_done1");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1, "ar_reload3");
        step(0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 8'd2, 1'b1, 1'b0, 1'b1, "ar_runload1");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1, "ar_dec1b");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, "ar_done2");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1, "ar_reload1");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, "ar_done3");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1, "ar_reload1b");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, "ar_abort");
        step(0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "ar_idle");

        // STEP=3 auto reload of 7, aborted after the first reload.
        step(1, 1'b1, 1'b1, 1'b1, 8'd7, 1'b0, 8'd7, 1'b1, 1'b0, 1'b1, "ar3_load7");
        step(1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b1, "ar3_dec4");
        step(1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1, "ar3_dec1");
        step(1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, "ar3_done");
        step(1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd7, 1'b1, 1'b0, 1'b1, "ar3_reload");
        step(1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, "ar3_abort");
`endif

        step(0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "final_idle");
        @(posedge clk);
        #2;
        tests++;
        if (q0.size() + q1.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q0.size() + q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
